pc_unit: RTL

- Parametrised next-generation program counter for the RISC-V core.
- Holds the fetch PC and selects the next PC from four sources: trap vector, execute-stage redirect, return-address-stack (RAS) prediction, and sequential increment.
- Supports a fetch handshake, stall, and misaligned-target fault detection.
- Sits between the fetch stage and the execute/trap logic.

---
 rtl/pc_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Fetch program counter. Selects the next PC from trap vector,
//            execute redirect, return-address-stack prediction or sequential
//            increment; detects misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              IALIGN       = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic            ras_empty,
    output logic            misalign_fault,
    output logic [XLEN-1:0] misalign_addr
);

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [XLEN-1:0] c_LOW_BITS   = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~c_LOW_BITS;
    localparam logic [XLEN-1:0] c_INC        = XLEN'(IALIGN);
    localparam int              c_PTR_W      = $clog2(RAS_DEPTH);
    localparam int              c_CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_pc;
    logic                r_pc_valid;
    logic                r_fault;
    logic [XLEN-1:0]     r_fault_addr;
    logic [XLEN-1:0]     r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0]  r_top;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_run;
    logic                w_fault;
    logic                w_advance;
    logic                w_empty;
    logic                w_redir_misaligned;
    logic                w_quiet;
    logic                w_pop;
    logic                w_push;
    logic [XLEN-1:0]     w_push_addr;
    logic [XLEN-1:0]     w_trap_pc;
    logic [c_PTR_W-1:0]  w_top_inc;
    logic [c_PTR_W-1:0]  w_wr_idx;

    assign w_run              = (r_state == S_RUN);
    assign w_fault            = (r_state == S_FAULT);
    assign w_advance          = fetch_ready & ~stall;
    assign w_empty            = (r_cnt == '0);
    assign w_redir_misaligned = |(redirect_target & c_LOW_BITS);
    // No trap or redirect this edge: only then may the RAS be touched.
    assign w_quiet            = w_run & ~trap_valid & ~redirect_valid;
    assign w_pop              = w_quiet & w_advance & ras_pop & ~w_empty;
    assign w_push             = w_quiet & ras_push;
    assign w_push_addr        = ras_push_addr & c_ALIGN_MASK;
    assign w_trap_pc          = trap_vector & c_ALIGN_MASK;
    assign w_top_inc          = r_top + c_PTR_W'(1);
    // A simultaneous pop frees the top slot, so the push reuses it.
    assign w_wr_idx           = w_pop ? r_top : w_top_inc;

    // Next-PC selection, FSM and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_HOLD;
            r_pc         <= RESET_VECTOR;
            r_pc_valid   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (trap_valid) begin
                        r_pc <= w_trap_pc;
                    end else if (redirect_valid) begin
                        if (w_redir_misaligned) begin
                            r_state      <= S_FAULT;
                            r_pc_valid   <= 1'b0;
                            r_fault      <= 1'b1;
                            r_fault_addr <= redirect_target;
                        end else begin
                            r_pc <= redirect_target;
                        end
                    end else if (w_pop) begin
                        r_pc <= r_ras[r_top];
                    end else if (w_advance) begin
                        r_pc <= r_pc + c_INC;
                    end
                end
                S_FAULT: begin
                    if (trap_valid) begin
                        r_state    <= S_RUN;
                        r_pc       <= w_trap_pc;
                        r_pc_valid <= 1'b1;
                        r_fault    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_HOLD;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    // RAS bookkeeping: top pointer and saturating occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (trap_valid & (w_run | w_fault)) begin
            r_cnt <= '0;
        end else if (w_push & ~w_pop) begin
            r_top <= w_top_inc;
            if (r_cnt != c_CNT_FULL) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end else if (w_pop & ~w_push) begin
            r_top <= r_top - c_PTR_W'(1);
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // RAS storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_wr_idx] <= w_push_addr;
        end
    end

    assign pc             = r_pc;
    assign pc_valid       = r_pc_valid;
    assign ras_empty      = w_empty;
    assign misalign_fault = r_fault;
    assign misalign_addr  = r_fault_addr;

endmodule
`default_nettype wire
